loop_pc_ctrl: RTL

//  Parametrised program counter for the BeeF core with a hardware loop stack.
//  CBB (']') jumps back in one cycle from a stored target, with no backward scan.
//  CBF ('[') with a zero cell runs a nesting-aware forward skip; the datapath is suppressed meanwhile.

---
 rtl/loop_pc_ctrl_pkg.sv | 40 ++++
 rtl/loop_pc_ctrl_if.sv | 35 +++
 rtl/loop_pc_ctrl_stack.sv | 60 ++++++
 rtl/loop_pc_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/loop_pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// loop_pc_ctrl_pkg
// Shared definitions for the BeeF program counter and its loop stack:
//   op_code      - one-hot 9-bit instruction encoding seen by the pc controller
//   pc_state_t   - controller states RUN / SKIP / FAULT
//   fault_code_t - sticky fault reason reported on fault_code
// ---------------------------------------------------------------------------
package loop_pc_ctrl_pkg;

    typedef enum logic [8:0] {
        OP_NOP   = 9'h001,
        OP_INC   = 9'h002,
        OP_DEC   = 9'h004,
        OP_RIGHT = 9'h008,
        OP_LEFT  = 9'h010,
        OP_OUT   = 9'h020,
        OP_IN    = 9'h040,
        OP_CBF   = 9'h080,   // '['
        OP_CBB   = 9'h100    // ']'
    } op_code;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SKIP  = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

    // Plain vector encodings of the states, for the legacy-style state register.
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_SKIP  = SKIP;
    localparam logic [1:0] ST_FAULT = FAULT;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_STACK_OVF = 2'd1,
        FC_STACK_UDF = 2'd2,
        FC_NEST_OVF  = 2'd3
    } fault_code_t;

endpackage

// File: rtl/loop_pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// loop_pc_ctrl_if
// Fetch/datapath side bundle of the pc controller.
//   master (fetch/test side): drives en, instruction, mem_read; observes the rest
//   slave  (loop_pc_ctrl)   : drives pc, busy, jump, depth, fault, fault_code
// ---------------------------------------------------------------------------
interface loop_pc_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 8
);
    import loop_pc_ctrl_pkg::*;

    localparam int DW = $clog2(DEPTH + 1);

    logic              en;
    op_code            instruction;
    logic [7:0]        mem_read;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              jump;
    logic [DW-1:0]     depth;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output en, instruction, mem_read,
        input  pc, busy, jump, depth, fault, fault_code
    );

    modport slave (
        input  en, instruction, mem_read,
        output pc, busy, jump, depth, fault, fault_code
    );

endinterface

// File: rtl/loop_pc_ctrl_stack.sv
// ---------------------------------------------------------------------------
// loop_stack
// Return-target stack for open '[' loops.
//   clk, reset (sync, active-low)
//   push/pop : one operation per cycle; push+pop together is not allowed
//   din      : value pushed (pc of the '[')
//   top      : most recently pushed entry (undefined when empty)
//   depth    : live occupancy, full/empty flags
// A push when full or a pop when empty is ignored here; the controller
// turns those cases into faults before they reach the stack.
// ---------------------------------------------------------------------------
module loop_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [DW-1:0] r_cnt;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    // Low bits of the count address the next free slot; the top is one below.
    assign w_wr_idx  = r_cnt[AW-1:0];
    assign w_top_idx = w_wr_idx - AW'(1);

    assign full  = (r_cnt == DW'(DEPTH));
    assign empty = (r_cnt == '0);
    assign depth = r_cnt;
    assign top   = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (push && !full) begin
            r_cnt <= r_cnt + DW'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - DW'(1);
        end
    end

    // Storage carries no reset: entries are only read below the live count.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/loop_pc_ctrl.sv
// ---------------------------------------------------------------------------
// loop_pc_ctrl
// Program counter for the BeeF core with a hardware loop stack.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : loop_pc_ctrl_if.slave
//           en, instruction, mem_read in; pc, busy, jump, depth, fault,
//           fault_code out (all registered)
// ']' with a non-zero cell reloads pc from the stacked '[' address + 1 in a
// single cycle. '[' with a zero cell enters SKIP, which walks forward counting
// nested brackets until the matching ']' while the datapath is held off.
// ---------------------------------------------------------------------------
module loop_pc_ctrl
    import loop_pc_ctrl_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              DEPTH    = 8,
    parameter int              NEST_W   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    loop_pc_ctrl_if.slave  bus
);

    localparam int              DW       = $clog2(DEPTH + 1);
    localparam logic [NEST_W-1:0] NEST_LAST = {NEST_W{1'b1}} - NEST_W'(1);

    logic [1:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [NEST_W-1:0] r_nest;
    logic              r_jump;
    logic [1:0]        r_fc;

    logic [1:0]        w_state_nx;
    logic [PC_W-1:0]   w_pc_nx;
    logic [NEST_W-1:0] w_nest_nx;
    logic              w_jump_nx;
    logic [1:0]        w_fc_nx;
    logic              w_push;
    logic              w_pop;

    logic [PC_W-1:0]   w_top;
    logic [DW-1:0]     w_depth;
    logic              w_full;
    logic              w_empty;
    logic [PC_W-1:0]   w_pc_inc;
    logic              w_is_cbf;
    logic              w_is_cbb;
    logic              w_cell_nz;

    loop_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_pc),
        .top   (w_top),
        .depth (w_depth),
        .full  (w_full),
        .empty (w_empty)
    );

    // Both increments wrap naturally at PC_W bits.
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_is_cbf  = (bus.instruction == OP_CBF);
    assign w_is_cbb  = (bus.instruction == OP_CBB);
    assign w_cell_nz = (bus.mem_read != 8'd0);

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_nest_nx  = r_nest;
        w_jump_nx  = 1'b0;
        w_fc_nx    = r_fc;
        w_push     = 1'b0;
        w_pop      = 1'b0;

        if (bus.en) begin
            case (r_state)
                ST_RUN: begin
                    if (w_is_cbf) begin
                        if (w_cell_nz) begin
                            if (w_full) begin
                                w_state_nx = ST_FAULT;
                                w_fc_nx    = FC_STACK_OVF;
                            end else begin
                                w_push  = 1'b1;
                                w_pc_nx = w_pc_inc;
                            end
                        end else begin
                            w_nest_nx  = '0;
                            w_pc_nx    = w_pc_inc;
                            w_state_nx = ST_SKIP;
                        end
                    end else if (w_is_cbb) begin
                        if (w_empty) begin
                            w_state_nx = ST_FAULT;
                            w_fc_nx    = FC_STACK_UDF;
                        end else if (w_cell_nz) begin
                            // Taken back-branch leaves the entry in place for the next pass.
                            w_pc_nx   = w_top + PC_W'(1);
                            w_jump_nx = 1'b1;
                        end else begin
                            w_pop   = 1'b1;
                            w_pc_nx = w_pc_inc;
                        end
                    end else begin
                        w_pc_nx = w_pc_inc;
                    end
                end

                ST_SKIP: begin
                    if (w_is_cbf) begin
                        // This '[' would push the nest count to its all-ones limit.
                        if (r_nest == NEST_LAST) begin
                            w_state_nx = ST_FAULT;
                            w_fc_nx    = FC_NEST_OVF;
                        end else begin
                            w_nest_nx = r_nest + NEST_W'(1);
                            w_pc_nx   = w_pc_inc;
                        end
                    end else if (w_is_cbb) begin
                        w_pc_nx = w_pc_inc;
                        if (r_nest != '0) begin
                            w_nest_nx = r_nest - NEST_W'(1);
                        end else begin
                            w_state_nx = ST_RUN;
                            w_jump_nx  = 1'b1;
                        end
                    end else begin
                        w_pc_nx = w_pc_inc;
                    end
                end

                default: begin
                    // FAULT: everything frozen until reset.
                    w_jump_nx = r_jump;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_nest  <= '0;
            r_jump  <= 1'b0;
            r_fc    <= FC_NONE;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_nest  <= w_nest_nx;
            r_jump  <= w_jump_nx;
            r_fc    <= w_fc_nx;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.busy       = (r_state == ST_SKIP);
    assign bus.jump       = r_jump;
    assign bus.depth      = w_depth;
    assign bus.fault      = (r_state == ST_FAULT);
    assign bus.fault_code = r_fc;

endmodule
